// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - start/done handshake, operand and result bundle for seq_alu
interface seq_alu_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) ();
    logic                   start;
    logic [3:0]             ALUOperation;
    logic [DATA_WIDTH-1:0]  A;
    logic [DATA_WIDTH-1:0]  B;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   busy;
    logic                   done;
    logic [DATA_WIDTH-1:0]  ALUResult;
    logic                   Zero;
    logic                   Error;

    modport master (
        output start, ALUOperation, A, B, shamt,
        input  busy, done, ALUResult, Zero, Error
    );

    modport slave (
        input  start, ALUOperation, A, B, shamt,
        output busy, done, ALUResult, Zero, Error
    );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle MIPS ALU with start/done handshake and iterative shifter
// Define SEQ_ALU_BARREL_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module seq_alu #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic      clk,
    input  logic      reset,
    seq_alu_if.slave  bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_NOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              op_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic [DATA_WIDTH-1:0]   result_q;
    logic                    zero_q;
    logic                    error_q;
    logic                    done_q;
    logic [DATA_WIDTH-1:0]   exec_result;
    logic                    exec_error;
`ifdef SEQ_ALU_BARREL_SHIFT_EN
    logic [SHAMT_WIDTH-1:0]  shamt_q;
`else
    logic [SHAMT_WIDTH-1:0]  cnt_q;
    logic                    is_shift;

    assign is_shift = (bus.ALUOperation == OP_SLL) || (bus.ALUOperation == OP_SRL);
`endif

    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.ALUResult = result_q;
    assign bus.Zero      = zero_q;
    assign bus.Error     = error_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
`ifdef SEQ_ALU_BARREL_SHIFT_EN
                    state_next = EXEC;
`else
                    state_next = is_shift ? SHIFT : EXEC;
`endif
                end
            end
            EXEC: state_next = IDLE;
`ifndef SEQ_ALU_BARREL_SHIFT_EN
            SHIFT: begin
                if (cnt_q == '0) begin
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // In the iterative build shift codes never reach EXEC, so they fall into the invalid arm there.
    always_comb begin
        exec_result = '0;
        exec_error  = 1'b0;
        case (op_q)
            OP_AND: exec_result = a_q & b_q;
            OP_OR:  exec_result = a_q | b_q;
            OP_NOR: exec_result = ~(a_q | b_q);
            OP_ADD: exec_result = a_q + b_q;
`ifdef SEQ_ALU_BARREL_SHIFT_EN
            OP_SLL: exec_result = b_q << shamt_q;
            OP_SRL: exec_result = b_q >> shamt_q;
`endif
            default: exec_error = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef SEQ_ALU_BARREL_SHIFT_EN
            shamt_q  <= '0;
`else
            cnt_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q <= bus.ALUOperation;
                        a_q  <= bus.A;
                        b_q  <= bus.B;
`ifdef SEQ_ALU_BARREL_SHIFT_EN
                        shamt_q <= bus.shamt;
`else
                        cnt_q   <= bus.shamt;
`endif
                    end
                end
                EXEC: begin
                    result_q <= exec_result;
                    zero_q   <= (exec_result == '0);
                    error_q  <= exec_error;
                    done_q   <= 1'b1;
                end
`ifndef SEQ_ALU_BARREL_SHIFT_EN
                // b_q doubles as the shift register; op_q[0] selects right (SRL) vs left (SLL).
                SHIFT: begin
                    if (cnt_q == '0) begin
                        result_q <= b_q;
                        zero_q   <= (b_q == '0);
                        error_q  <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        b_q   <= op_q[0] ? (b_q >> 1) : (b_q << 1);
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule
